// File: rtl/video_pkg.sv
// Shared timing defaults, control-bundle type and total-period helper for the video timing generator.
package video_pkg;

    localparam int unsigned CNT_W     = 9;
    localparam int unsigned MAX_TOTAL = 512;

    localparam int unsigned DEF_H_ACTIVE = 288;
    localparam int unsigned DEF_H_FP     = 20;
    localparam int unsigned DEF_H_SYNC   = 32;
    localparam int unsigned DEF_H_BP     = 44;
    localparam int unsigned DEF_V_ACTIVE = 224;
    localparam int unsigned DEF_V_FP     = 11;
    localparam int unsigned DEF_V_SYNC   = 7;
    localparam int unsigned DEF_V_BP     = 21;
    localparam int unsigned DEF_CW       = 12;
    localparam int unsigned DEF_PIX_LAT  = 1;

    // Blanking/sync/enable bundle carried down the alignment delay line
    typedef struct packed {
        logic de;
        logic hblk;
        logic vblk;
        logic hsyn_n;
        logic vsyn_n;
    } vtg_ctl_t;

    // Inactive bundle: fully blanked, syncs released
    localparam vtg_ctl_t CTL_IDLE = '{de: 1'b0, hblk: 1'b1, vblk: 1'b1, hsyn_n: 1'b1, vsyn_n: 1'b1};

    // Total period of one axis from its four segments
    function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtg_delay.sv
// Clock-enable gated shift register with a preset reset value; exposes the last stage and its input.
module vtg_delay #(
    parameter int unsigned    W       = 1,
    parameter int unsigned    DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] pre
);

    localparam int unsigned SR_W = W * DEPTH;

    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_d;

    // Shift one stage per enable; stage 0 occupies the low bits
    always_comb begin
        sr_d = sr_q;
        if (ce) begin
            sr_d = SR_W'({sr_q, din});
        end
    end

    // Stage register, preset to the idle value on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= {DEPTH{RST_VAL}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[SR_W-1 -: W];

    // Value that the final stage will take on the next enable
    if (DEPTH == 1) begin : g_pre_direct
        assign pre = din;
    end else begin : g_pre_tap
        assign pre = sr_q[SR_W-W-1 -: W];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, offsettable syncs, and pixel-aligned blank/sync/DE/RGB outputs.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned PIX_LAT  = DEF_PIX_LAT
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             CE_PIX,
    input  logic [3:0]       H_OFS,
    input  logic [2:0]       V_OFS,
    input  logic [CW-1:0]    iRGB,
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    output logic [CW-1:0]    oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             DE,
    output logic             LINE_START,
    output logic             FRAME_START
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_PRE_ACT = CNT_W'(V_ACTIVE - 1);

    localparam int HS_BASE = int'(H_ACTIVE + H_FP);
    localparam int VS_BASE = int'(V_ACTIVE + V_FP);
    localparam int HS_LEN  = int'(H_SYNC);
    localparam int VS_LEN  = int'(V_SYNC);

    // Porches must absorb the full sync offset range; counters are 9 bits wide
    if (H_FP <= 8 || H_BP <= 8) begin : g_bad_hporch
        $error("video_timing_gen: horizontal porches must exceed 8 pixels");
    end
    if (V_FP <= 4 || V_BP <= 4) begin : g_bad_vporch
        $error("video_timing_gen: vertical porches must exceed 4 lines");
    end
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("video_timing_gen: line or frame total exceeds counter range");
    end
    if (PIX_LAT > 3) begin : g_bad_lat
        $error("video_timing_gen: PIX_LAT must be 0..3");
    end

    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    logic signed [3:0] hofs_q, hofs_d;
    logic signed [2:0] vofs_q, vofs_d;
    logic [CW-1:0]     rgb_q, rgb_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;

    logic     h_wrap_c;
    int       hc_c, vc_c, hs_lo_c, vs_lo_c;
    vtg_ctl_t ctl_c;
    vtg_ctl_t dly_out;
    vtg_ctl_t dly_pre;

    assign h_wrap_c = (hcnt_q == H_LAST);

    // Blank/sync/DE decode for the current counter position
    always_comb begin
        hc_c    = int'(hcnt_q);
        vc_c    = int'(vcnt_q);
        hs_lo_c = HS_BASE + int'(hofs_q);
        vs_lo_c = VS_BASE + int'(vofs_q);
        ctl_c        = CTL_IDLE;
        ctl_c.hblk   = (hcnt_q >= H_ACT);
        ctl_c.vblk   = (vcnt_q >= V_ACT);
        ctl_c.de     = ~(ctl_c.hblk | ctl_c.vblk);
        ctl_c.hsyn_n = ~((hc_c >= hs_lo_c) && (hc_c < hs_lo_c + HS_LEN));
        ctl_c.vsyn_n = ~((vc_c >= vs_lo_c) && (vc_c < vs_lo_c + VS_LEN));
    end

    // Counter advance, offset capture at vblank start, pulses and pixel gating
    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        hofs_d        = hofs_q;
        vofs_d        = vofs_q;
        rgb_d         = rgb_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (CE_PIX) begin
            if (h_wrap_c) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
                if (vcnt_q == V_PRE_ACT) begin
                    hofs_d = H_OFS;
                    vofs_d = V_OFS;
                end
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
            line_start_d  = h_wrap_c;
            frame_start_d = h_wrap_c && (vcnt_d == '0);
            rgb_d         = dly_pre.de ? iRGB : '0;
        end
    end

    // State registers; reset parks counters on the last position so the first enable lands on 0,0
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            hofs_q        <= '0;
            vofs_q        <= '0;
            rgb_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hofs_q        <= hofs_d;
            vofs_q        <= vofs_d;
            rgb_q         <= rgb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Align control outputs with the registered pixel
    vtg_delay #(
        .W      ($bits(vtg_ctl_t)),
        .DEPTH  (PIX_LAT + 1),
        .RST_VAL(CTL_IDLE)
    ) u_dly (
        .clk (MCLK),
        .rst (RESET),
        .ce  (CE_PIX),
        .din (ctl_c),
        .dout(dly_out),
        .pre (dly_pre)
    );

    assign HPOS        = hcnt_q;
    assign VPOS        = vcnt_q;
    assign oRGB        = rgb_q;
    assign HBLK        = dly_out.hblk;
    assign VBLK        = dly_out.vblk;
    assign HSYN        = dly_out.hsyn_n;
    assign VSYN        = dly_out.vsyn_n;
    assign DE          = dly_out.de;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: four instances (PIX_LAT 0..3) against a CE-count based raster model.
module tb_video_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 10;
    localparam int HSW = 4;
    localparam int HBP = 10;
    localparam int VA  = 8;
    localparam int VFP = 5;
    localparam int VSW = 2;
    localparam int VBP = 5;
    localparam int CW  = 12;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int NL  = 4;

    localparam logic [4:0] IDLE = 5'b01111;

    logic mclk = 1'b0;
    logic rst;
    logic ce;
    logic [3:0] h_ofs;
    logic [2:0] v_ofs;
    logic [NL-1:0][CW-1:0] irgb;
    logic [NL-1:0][CW-1:0] orgb;
    logic [NL-1:0][8:0]    hpos;
    logic [NL-1:0][8:0]    vpos;
    logic [NL-1:0] hblk, vblk, hsyn, vsyn, de, ls, fs;

    always #5 mclk = ~mclk;

    for (genvar p = 0; p < NL; p++) begin : g_dut
        video_timing_gen #(
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
            .CW(CW), .PIX_LAT(p)
        ) u_dut (
            .MCLK(mclk), .RESET(rst), .CE_PIX(ce), .H_OFS(h_ofs), .V_OFS(v_ofs),
            .iRGB(irgb[p]), .HPOS(hpos[p]), .VPOS(vpos[p]), .oRGB(orgb[p]),
            .HBLK(hblk[p]), .VBLK(vblk[p]), .HSYN(hsyn[p]), .VSYN(vsyn[p]), .DE(de[p]),
            .LINE_START(ls[p]), .FRAME_START(fs[p])
        );
    end

    // Reference model state: n = CEs since reset, hist[m] = expected control bundle at CE m
    int         n;
    int         cur_hofs, cur_vofs;
    int         off_h, off_v;
    bit         last_ce;
    logic [4:0] hist[$];
    int         errors;
    int         checks;

    function automatic int pos_h(input int m);
        return ((m + HT * VT - 1) % (HT * VT)) % HT;
    endfunction

    function automatic int pos_v(input int m);
        return ((m + HT * VT - 1) % (HT * VT)) / HT;
    endfunction

    function automatic logic [CW-1:0] pix(input int m);
        return CW'(pos_v(m) * 64 + pos_h(m) + 1);
    endfunction

    // {de, hblk, vblk, hsyn_n, vsyn_n} for raster position of CE m under given offsets
    function automatic logic [4:0] ctl_of(input int m, input int oh, input int ov);
        int h = pos_h(m);
        int v = pos_v(m);
        bit hb = (h >= HA);
        bit vb = (v >= VA);
        bit hs_low = (h >= HA + HFP + oh) && (h < HA + HFP + oh + HSW);
        bit vs_low = (v >= VA + VFP + ov) && (v < VA + VFP + ov + VSW);
        return {~(hb | vb), hb, vb, ~hs_low, ~vs_low};
    endfunction

    function automatic logic [36:0] expect_vec(input int p);
        int idx = n - p - 1;
        logic [4:0] a = (idx >= 0) ? hist[idx] : IDLE;
        logic [CW-1:0] rgb = (idx >= 0 && a[4]) ? pix(idx) : '0;
        bit l = last_ce && (pos_h(n) == 0);
        bit f = l && (pos_v(n) == 0);
        return {9'(pos_h(n)), 9'(pos_v(n)), rgb, a[3], a[2], a[1], a[0], a[4], l, f};
    endfunction

    function automatic logic [36:0] got_vec(input int p);
        return {hpos[p], vpos[p], orgb[p], hblk[p], vblk[p], hsyn[p], vsyn[p], de[p], ls[p], fs[p]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One MCLK: drive at negedge, advance model at posedge, compare all instances just after
    task automatic step(input bit ce_v, input bit rst_v);
        @(negedge mclk);
        rst   = rst_v;
        ce    = ce_v;
        h_ofs = 4'(cur_hofs);
        v_ofs = 3'(cur_vofs);
        for (int p = 0; p < NL; p++) begin
            irgb[p] = (n - p >= 0) ? pix(n - p) : CW'($urandom);
        end
        @(posedge mclk);
        if (rst_v) begin
            n = 0;
            off_h = 0;
            off_v = 0;
            hist.delete();
            hist.push_back(ctl_of(0, 0, 0));
            last_ce = 1'b0;
        end else if (ce_v) begin
            n++;
            if (pos_h(n) == 0 && pos_v(n) == VA) begin
                off_h = cur_hofs;
                off_v = cur_vofs;
            end
            hist.push_back(ctl_of(n, off_h, off_v));
            last_ce = 1'b1;
        end else begin
            last_ce = 1'b0;
        end
        #1;
        for (int p = 0; p < NL; p++) begin
            check_eq($sformatf("lat%0d_ce%0d", p, n), 64'(got_vec(p)), 64'(expect_vec(p)));
        end
    endtask

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int guard;
        int hmin_a, hmax_a, hmin_b, hmax_b, vmin, vmax;
        int fs_cnt, hb_cnt, vb_cnt, pulse_cnt, change_cnt;
        logic [36:0] snap;

        errors = 0; checks = 0; n = 0; last_ce = 1'b0;
        cur_hofs = 0; cur_vofs = 0; off_h = 0; off_v = 0;
        hist.push_back(ctl_of(0, 0, 0));
        rst = 1'b1; ce = 1'b0; h_ofs = '0; v_ofs = '0; irgb = '0;

        // Reset and idle hold
        repeat (3) step(1'($urandom_range(1)), 1'b1);
        repeat (4) step(1'b0, 1'b0);

        // Random enables with random offsets
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                cur_hofs = int'($urandom_range(15)) - 8;
                cur_vofs = int'($urandom_range(7)) - 4;
            end
            step(1'($urandom_range(1)), 1'b0);
        end

        // Settle offsets to zero, then change them mid-frame
        cur_hofs = 0; cur_vofs = 0;
        guard = 0;
        do begin step(1'b1, 1'b0); guard++; end
        while (!(pos_h(n) == 0 && pos_v(n) == VA) && guard < 2 * HT * VT);
        check_eq("reach_vblank", 64'(pos_v(n)), 64'(VA));
        guard = 0;
        do begin step(1'b1, 1'b0); guard++; end
        while (!(pos_h(n) == 0 && pos_v(n) == 3) && guard < 2 * HT * VT);
        check_eq("reach_line3", 64'(pos_v(n)), 64'd3);
        cur_hofs = 7; cur_vofs = -4;
        hmin_a = 999; hmax_a = -1; hmin_b = 999; hmax_b = -1; vmin = 999; vmax = -1;
        for (int i = 0; i < HT * VT; i++) begin
            int av, ah;
            step(1'b1, 1'b0);
            av = pos_v(n - 1);
            ah = pos_h(n - 1);
            if (!hsyn[0] && av >= 4 && av < VA) begin
                hmin_a = (ah < hmin_a) ? ah : hmin_a; hmax_a = (ah > hmax_a) ? ah : hmax_a;
            end
            if (!hsyn[0] && av >= VA) begin
                hmin_b = (ah < hmin_b) ? ah : hmin_b; hmax_b = (ah > hmax_b) ? ah : hmax_b;
            end
            if (!vsyn[0] && av >= VA) begin
                vmin = (av < vmin) ? av : vmin; vmax = (av > vmax) ? av : vmax;
            end
        end
        check_eq("hsync_old_lo", 64'(hmin_a), 64'(HA + HFP));
        check_eq("hsync_old_hi", 64'(hmax_a), 64'(HA + HFP + HSW - 1));
        check_eq("hsync_new_lo", 64'(hmin_b), 64'(HA + HFP + 7));
        check_eq("hsync_new_hi", 64'(hmax_b), 64'(HA + HFP + 7 + HSW - 1));
        check_eq("vsync_new_lo", 64'(vmin), 64'(VA + VFP - 4));
        check_eq("vsync_new_hi", 64'(vmax), 64'(VA + VFP - 4 + VSW - 1));

        // One full frame with an enable every 8 clocks
        fs_cnt = 0; hb_cnt = 0; vb_cnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            repeat (7) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            fs_cnt += int'(fs[0]);
            hb_cnt += int'(hblk[0]);
            vb_cnt += int'(vblk[0]);
        end
        check_eq("frame_starts", 64'(fs_cnt), 64'd1);
        check_eq("hblk_per_frame", 64'(hb_cnt), 64'((HT - HA) * VT));
        check_eq("vblk_lines", 64'(vb_cnt / HT), 64'(VT - VA));

        // Reset mid-line within the active area
        guard = 0;
        do begin step(1'b1, 1'b0); guard++; end
        while (!(pos_h(n) == 12 && pos_v(n) == 4) && guard < 2 * HT * VT);
        check_eq("reach_mid_line", 64'(pos_h(n)), 64'd12);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int p = 0; p < NL; p++) begin
            check_eq($sformatf("rst_hpos%0d", p), 64'(hpos[p]), 64'd0);
            check_eq($sformatf("rst_vpos%0d", p), 64'(vpos[p]), 64'd0);
            check_eq($sformatf("rst_fs%0d", p), 64'(fs[p]), 64'd1);
            check_eq($sformatf("rst_rgb%0d", p), 64'(orgb[p]), 64'd0);
        end

        // Enable held low for 1000 clocks mid-line
        guard = 0;
        do begin step(1'b1, 1'b0); guard++; end
        while (!(pos_h(n) == 10 && pos_v(n) == 2) && guard < 2 * HT * VT);
        step(1'b0, 1'b0);
        snap = got_vec(2);
        pulse_cnt = 0; change_cnt = 0;
        repeat (1000) begin
            step(1'b0, 1'b0);
            for (int p = 0; p < NL; p++) pulse_cnt += int'(ls[p]) + int'(fs[p]);
            if (got_vec(2) !== snap) change_cnt++;
        end
        check_eq("stall_pulses", 64'(pulse_cnt), 64'd0);
        check_eq("stall_changes", 64'(change_cnt), 64'd0);
        check_eq("stall_hpos", 64'(hpos[2]), 64'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
